// File: rtl/module_post_pool_if.sv
// Pixel stream bundle between the accumulator, post-pool stage and write-back.
// Ports: in_valid/in_data carry 18-bit signed accumulations into the stage;
//        out_valid/out_data carry 8-bit signed quantised pixels out of it.
interface module_post_pool_if;
  logic               in_valid;
  logic signed [17:0] in_data;
  logic               out_valid;
  logic signed [7:0]  out_data;

  // master drives the input stream and observes results
  modport master (output in_valid, in_data, input out_valid, out_data);
  // slave is the post-pool stage itself
  modport slave  (input in_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/module_post_pool.sv
// Bias add, optional leaky ReLU, requantise to int8, optional 2x2/2 max pool.
// Latency: 3 cycles unpooled, 4 cycles from window bottom-right when pooled; done at +4.
// No backpressure: input accepted whenever in_valid is high in RUN, ignored in IDLE.
// Ports: clk, rst (sync, active high); cfg_* and bias latched on cfg_start;
//        px (slave) pixel stream; busy high in RUN; done pulses once per frame.
module module_post_pool #(
  parameter int MAX_WIDTH = 112,
  parameter int COL_BIT   = 7,
  parameter int ROW_BIT   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [COL_BIT-1:0]  cfg_width,
  input  logic [ROW_BIT-1:0]  cfg_height,
  input  logic                cfg_pool_en,
  input  logic                cfg_leaky_en,
  input  logic [3:0]          cfg_shift,
  input  logic signed [17:0]  bias,
  module_post_pool_if.slave   px,
  output logic                busy,
  output logic                done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Per-pixel tag: config rides along so a new frame can start while the
  // previous one is still draining.
  typedef struct packed {
    logic               vld;
    logic               last;
    logic               pool;
    logic               leaky;
    logic [3:0]         shift;
    logic [ROW_BIT-1:0] row;
    logic [COL_BIT-1:0] col;
  } tag_t;

  state_t state, state_nxt;
  logic   accept;
  logic   at_end;

  logic [COL_BIT-1:0] w_q, col;
  logic [ROW_BIT-1:0] h_q, row;
  logic               pool_q, leaky_q;
  logic [3:0]         shift_q;
  logic signed [17:0] bias_q;

  tag_t               t1, t2, t3;
  logic signed [18:0] s1, s2;
  logic signed [7:0]  q3;

  logic signed [19:0] rnd_add, rnd_sum, rnd_shr;
  logic signed [7:0]  q_nxt;

  logic signed [7:0]  pair;
  logic signed [7:0]  m;
  logic signed [7:0]  lb_rd;
  logic [COL_BIT-2:0] lb_addr;
  logic [7:0]         linebuf [MAX_WIDTH/2];
  logic               p4_vld;
  logic signed [7:0]  p4_dat;

  assign at_end = (col == w_q - COL_BIT'(1)) && (row == h_q - ROW_BIT'(1));

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = (state == RUN);
    case (state)
      IDLE: if (cfg_start) state_nxt = RUN;
      RUN: begin
        accept = px.in_valid;
        if (px.in_valid && at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Config latch and raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0; h_q <= '0; pool_q <= 1'b0; leaky_q <= 1'b0;
      shift_q <= '0; bias_q <= '0; col <= '0; row <= '0;
    end else if (state == IDLE && cfg_start) begin
      w_q <= cfg_width; h_q <= cfg_height; pool_q <= cfg_pool_en;
      leaky_q <= cfg_leaky_en; shift_q <= cfg_shift; bias_q <= bias;
      col <= '0; row <= '0;
    end else if (accept) begin
      if (col == w_q - COL_BIT'(1)) begin
        col <= '0;
        row <= row + ROW_BIT'(1);
      end else begin
        col <= col + COL_BIT'(1);
      end
    end
  end

  // Round half up: add 2^(S-1) before the floor shift; saturate to int8.
  always_comb begin
    rnd_add = (t2.shift == 4'd0) ? 20'sd0 : (20'sd1 <<< (t2.shift - 4'd1));
    rnd_sum = {s2[18], s2} + rnd_add;
    rnd_shr = rnd_sum >>> t2.shift;
    if (rnd_shr > 20'sd127)       q_nxt = 8'h7f;
    else if (rnd_shr < -20'sd128) q_nxt = 8'h80;
    else                          q_nxt = rnd_shr[7:0];
  end

  // Pool datapath: horizontal max of the pair, then vertical max against the
  // half-row stored by the even row at the same column pair.
  assign lb_addr = t3.col[COL_BIT-1:1];
  assign lb_rd   = linebuf[lb_addr];
  assign m       = (pair > q3) ? pair : q3;

  always_ff @(posedge clk) begin
    if (rst) begin
      t1 <= '0; t2 <= '0; t3 <= '0;
      s1 <= '0; s2 <= '0; q3 <= '0;
      pair <= '0; p4_vld <= 1'b0; p4_dat <= '0; done <= 1'b0;
    end else begin
      t1 <= '{vld: accept, last: accept && at_end, pool: pool_q,
              leaky: leaky_q, shift: shift_q, row: row, col: col};
      s1 <= $signed({px.in_data[17], px.in_data}) + $signed({bias_q[17], bias_q});

      t2 <= t1;
      s2 <= (t1.leaky && s1[18]) ? (s1 >>> 3) : s1;

      t3 <= t2;
      q3 <= q_nxt;

      if (t3.vld && t3.pool && !t3.col[0]) pair <= q3;
      p4_vld <= t3.vld && t3.pool && t3.col[0] && t3.row[0];
      p4_dat <= (lb_rd > m) ? lb_rd : m;
      done   <= t3.vld && t3.last;
    end
  end

  // Line buffer holds no reset: each even row writes a slot before the odd row reads it.
  always_ff @(posedge clk) begin
    if (t3.vld && t3.pool && t3.col[0] && !t3.row[0]) linebuf[lb_addr] <= m;
  end

  // Pooled and unpooled frames cannot collide on the output: a frame boundary
  // always spans at least two cycles of pipeline separation.
  assign px.out_valid = p4_vld || (t3.vld && !t3.pool);
  assign px.out_data  = p4_vld ? p4_dat : q3;

endmodule
